csel_adder_pipe: RTL

Parametrised, two-stage pipelined carry-select adder/subtractor. It is the successor to the fixed 2-bit carry-select slice.
- Width and block size are generic.
- Adds a subtract mode, signed-overflow detection and a valid/ready handshake with full backpressure.
- Sits between operand producers and the datapath result bus; sustains one operation per cycle.

---
 rtl/csel_adder_pipe.sv | 133 +++++++++++++
 1 files changed

// File: rtl/csel_adder_pipe.sv
// Two-stage pipelined carry-select adder/subtractor with valid/ready flow control.
// Optional saturation on signed overflow: define CSEL_SAT_EN.
module csel_adder_pipe #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int BW = (BLOCK < 1) ? 1 : BLOCK;
  localparam int NB = WIDTH / BW;

  generate
    if (BLOCK < 1) begin : g_bad_block
      $error("csel_adder_pipe: BLOCK must be >= 1");
    end else if ((WIDTH % BLOCK) != 0) begin : g_bad_width
      $error("csel_adder_pipe: WIDTH must be a multiple of BLOCK");
    end
  endgenerate

  logic s1_valid;
  logic s1_adv;
  logic s2_adv;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  logic [WIDTH-1:0]       b_eff;
  logic                   cin_eff;
  logic [NB-1:0][BW-1:0]  sum0_d;
  logic [NB-1:0][BW-1:0]  sum1_d;
  logic [NB-1:0]          c0_d;
  logic [NB-1:0]          c1_d;

  // Both carry hypotheses per block, resolved by the select chain in S2
  always_comb begin
    b_eff   = in_sub ? ~in_b : in_b;
    cin_eff = in_sub | in_cin;
    for (int k = 0; k < NB; k++) begin
      {c0_d[k], sum0_d[k]} = {1'b0, in_a[k*BW +: BW]}
                           + {1'b0, b_eff[k*BW +: BW]};
      {c1_d[k], sum1_d[k]} = {1'b0, in_a[k*BW +: BW]}
                           + {1'b0, b_eff[k*BW +: BW]}
                           + {{BW{1'b0}}, 1'b1};
    end
  end

  logic [NB-1:0][BW-1:0]  s1_sum0;
  logic [NB-1:0][BW-1:0]  s1_sum1;
  logic [NB-1:0]          s1_c0;
  logic [NB-1:0]          s1_c1;
  logic                   s1_cin;
  logic                   s1_amsb;
  logic                   s1_bmsb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sum0  <= '0;
      s1_sum1  <= '0;
      s1_c0    <= '0;
      s1_c1    <= '0;
      s1_cin   <= 1'b0;
      s1_amsb  <= 1'b0;
      s1_bmsb  <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sum0  <= sum0_d;
        s1_sum1  <= sum1_d;
        s1_c0    <= c0_d;
        s1_c1    <= c1_d;
        s1_cin   <= cin_eff;
        s1_amsb  <= in_a[WIDTH-1];
        s1_bmsb  <= b_eff[WIDTH-1];
      end
    end
  end

  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] res_d;
  logic             cy;
  logic             ovf_d;

  always_comb begin
    cy    = s1_cin;
    sum_d = '0;
    for (int k = 0; k < NB; k++) begin
      sum_d[k*BW +: BW] = cy ? s1_sum1[k] : s1_sum0[k];
      cy = cy ? s1_c1[k] : s1_c0[k];
    end
    ovf_d = (s1_amsb == s1_bmsb) && (sum_d[WIDTH-1] != s1_amsb);
`ifdef CSEL_SAT_EN
    if (ovf_d)
      res_d = s1_amsb ? {1'b1, {(WIDTH-1){1'b0}}}
                      : {1'b0, {(WIDTH-1){1'b1}}};
    else
      res_d = sum_d;
`else
    res_d = sum_d;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_sum  <= res_d;
        out_cout <= cy;
        out_ovf  <= ovf_d;
      end
    end
  end

endmodule
